// File: rtl/tune_ctrl_if.sv
// Configuration/datapath bundle for the tuning controller.
// master drives configuration and strobes; slave returns committed NCO settings.
interface tune_ctrl_if;
  logic        cfg_valid;
  logic [15:0] cfg_word;
  logic        sample_tick;
  logic        scan_en;
  logic [15:0] scan_step;
  logic [7:0]  dwell;
  logic [15:0] phase_inc;
  logic [1:0]  gain;
  logic        busy;
  logic        update;

  modport master (
    output cfg_valid, cfg_word, sample_tick, scan_en, scan_step, dwell,
    input  phase_inc, gain, busy, update
  );

  modport slave (
    input  cfg_valid, cfg_word, sample_tick, scan_en, scan_step, dwell,
    output phase_inc, gain, busy, update
  );
endinterface

// File: rtl/tune_ctrl.sv
// Tuning controller: holds host configuration words until a sample-tick boundary,
// and runs an autonomous band scan of the phase increment when no host word is pending.
module tune_ctrl #(
  parameter logic [15:0] SCAN_LO   = 16'h0400,
  parameter logic [15:0] SCAN_HI   = 16'h1000,
  parameter logic [15:0] RST_PHASE = 16'h0988
) (
  input  logic         CLK,
  input  logic         RSTb,
  tune_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    SCAN = 2'd2
  } state_t;

  state_t      state_q;
  logic [15:0] phase_q;
  logic [1:0]  gain_q;
  logic [15:0] pend_q;
  logic        busy_q;
  logic        update_q;
  logic [7:0]  dwell_cnt_q;

  logic [16:0] scan_sum_d;
  logic [15:0] scan_next_d;

  // Next scan channel: anything outside [SCAN_LO, SCAN_HI] restarts the band at SCAN_LO.
  always_comb begin
    scan_sum_d  = {1'b0, phase_q} + {1'b0, bus.scan_step};
    scan_next_d = scan_sum_d[15:0];
    if ((scan_sum_d > {1'b0, SCAN_HI}) || (scan_sum_d < {1'b0, SCAN_LO})) begin
      scan_next_d = SCAN_LO;
    end else begin
      scan_next_d = scan_sum_d[15:0];
    end
  end

  // Control FSM; a new host word always wins over a same-cycle tick.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      state_q     <= IDLE;
      phase_q     <= RST_PHASE;
      gain_q      <= 2'b00;
      pend_q      <= 16'h0000;
      busy_q      <= 1'b0;
      update_q    <= 1'b0;
      dwell_cnt_q <= 8'd0;
    end else begin
      update_q <= 1'b0;
      if (bus.cfg_valid) begin
        pend_q  <= bus.cfg_word;
        busy_q  <= 1'b1;
        state_q <= PEND;
      end else begin
        case (state_q)
          IDLE: begin
            if (bus.scan_en) begin
              state_q <= SCAN;
            end else begin
              state_q <= IDLE;
            end
          end
          PEND: begin
            if (bus.sample_tick) begin
              phase_q     <= pend_q;
              gain_q      <= pend_q[1:0];
              busy_q      <= 1'b0;
              dwell_cnt_q <= 8'd0;
              update_q    <= 1'b1;
              state_q     <= bus.scan_en ? SCAN : IDLE;
            end else begin
              state_q <= PEND;
            end
          end
          SCAN: begin
            if (!bus.scan_en) begin
              dwell_cnt_q <= 8'd0;
              state_q     <= IDLE;
            end else if (bus.sample_tick) begin
              if (dwell_cnt_q == bus.dwell) begin
                phase_q     <= scan_next_d;
                dwell_cnt_q <= 8'd0;
                update_q    <= 1'b1;
              end else begin
                dwell_cnt_q <= dwell_cnt_q + 8'd1;
              end
            end else begin
              state_q <= SCAN;
            end
          end
          default: begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            dwell_cnt_q <= 8'd0;
          end
        endcase
      end
    end
  end

  assign bus.phase_inc = phase_q;
  assign bus.gain      = gain_q;
  assign bus.busy      = busy_q;
  assign bus.update    = update_q;

endmodule

// File: doc/tune_ctrl.md
# tune_ctrl

Tuning controller between the SPI configuration receiver and the NCO/gain datapath of the 1-bit AM radio. Captures completed configuration words, holds them pending, and commits them to the datapath only on a sample-tick boundary so the NCO never sees a mid-sample change. Also runs an autonomous band-scan mode that steps the phase increment across a bounded range with a programmable dwell; host writes always take priority over scan steps.

## Interface
- SCAN_LO, 16'h0400, lowest phase increment reached by scan (inclusive)
- SCAN_HI, 16'h1000, highest phase increment reached by scan (inclusive); SCAN_LO <= SCAN_HI
- RST_PHASE, 16'h0988, phase_inc value after reset
- CLK  in  1  system clock; all logic on rising edge
- RSTb  in  1  reset, asynchronous, active-low
- cfg_valid  in  1  one-cycle pulse: cfg_word holds a completed SPI frame
- cfg_word  in  16  configuration word; [15:0] = phase increment, [1:0] = gain
- sample_tick  in  1  one-cycle datapath sample strobe; the only commit point
- scan_en  in  1  level; 1 = band scan active
- scan_step  in  16  phase increment added per scan step
- dwell  in  8  sample ticks spent on each scan channel, minus one
- phase_inc  out  16  committed NCO phase increment
- gain  out  2  committed gain select
- busy  out  1  a host word is pending (not yet committed)
- update  out  1  one-cycle pulse in the cycle after phase_inc/gain change

## Operation
- Reset (async): phase_inc = RST_PHASE, gain = 2'b00, pend_word = 0, busy = 0, update = 0, dwell_cnt = 0, state = IDLE.
- Capture: cfg_valid=1 in any state -> pend_word <= cfg_word, busy <= 1. A second cfg_valid before commit overwrites pend_word (last write wins).
- States: IDLE (scan_en=0, busy=0), PEND (busy=1), SCAN (scan_en=1, busy=0).
  - IDLE -> PEND on cfg_valid; IDLE -> SCAN when scan_en=1.
  - PEND -> IDLE/SCAN (per scan_en) on sample_tick: phase_inc <= pend_word, gain <= pend_word[1:0], busy <= 0, dwell_cnt <= 0, update pulse.
  - SCAN: on sample_tick, if dwell_cnt == dwell then step and dwell_cnt <= 0, else dwell_cnt <= dwell_cnt+1. SCAN -> PEND on cfg_valid; SCAN -> IDLE when scan_en=0 (dwell_cnt <= 0, phase_inc held).
- Scan step: sum = {1'b0,phase_inc} + {1'b0,scan_step} (17 bits). If sum > SCAN_HI or sum < SCAN_LO (the latter applies only when phase_inc < SCAN_LO on entry), phase_inc <= SCAN_LO; else phase_inc <= sum[15:0]. Gain unchanged by scan. update pulses on every step, including a wrap to SCAN_LO.
- scan_step = 0: step reloads the same value (or SCAN_LO if out of range); update still pulses.
- Priority: pending host commit beats a scan step on the same tick; the scan step is dropped, dwell restarts from 0.

## Timing
- cfg_valid in cycle N sets busy visible at N+1; earliest commit is the first sample_tick in cycle M >= N+1; phase_inc/gain change at M+1 with update=1 at M+1 only.
- cfg_valid and sample_tick both in cycle N: tick does not commit the new word; it commits at the next tick. Any older pending word is overwritten in N and is not committed by that tick.
- Scan step latency: registered at tick cycle + 1; with dwell = D, consecutive steps are D+1 ticks apart.
- scan_en sampled every cycle; deassertion takes effect next cycle, including over a tick in the same cycle (that tick is ignored for scan).
- RSTb asserted mid-pend or mid-scan: all state returns to reset values immediately; pending word is lost.
- Outputs are registers; no combinational input-to-output path.

## Test plan
- Reset then idle: phase_inc=16'h0988, gain=0, busy=0, update=0; 100 ticks with no cfg_valid -> no change.
- cfg_valid with 16'h1235, tick 5 cycles later -> busy=1 until tick, then phase_inc=16'h1235, gain=2'b01, one update pulse.
- cfg_valid 16'h2000 then 16'h3003 before any tick; cfg_valid coincident with tick -> only 16'h3003 committed, on the following tick.
- scan_en=1, scan_step=16'h0100, dwell=2, phase_inc=16'h0F80 -> after 3 ticks 16'h1080 > SCAN_HI so phase_inc=16'h0400; 3 ticks later 16'h0500.
- During scan, cfg_valid 16'h0800 with tick landing where dwell expires -> phase_inc=16'h0800 (no step), dwell restarts, next step at 16'h0900 after dwell+1 ticks.
- Assert RSTb low mid-pend while scanning -> outputs return to reset values asynchronously; after release no update until new stimulus.
